// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register: 1-cycle latency, FIFO order, flush drops every held entry.
// Define PIPE_STAGE_SKID_EN for a two-entry build with registered in_ready; otherwise in_ready follows out_ready.
module pipe_stage_reg #(
    parameter int CTRL_WIDTH = 8,
    parameter int DATA_WIDTH = 128,
    parameter logic [CTRL_WIDTH-1:0] CTRL_SAFE = {CTRL_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    logic                  r_m_vld;
    logic [CTRL_WIDTH-1:0] r_m_ctrl;
    logic [DATA_WIDTH-1:0] r_m_dat;
    logic                  w_m_free;
    logic                  w_in_xfer;

    // M can take a new entry this edge if it is empty or being drained.
    assign w_m_free  = !r_m_vld | out_ready;
    assign w_in_xfer = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic                  r_s_vld;
    logic [CTRL_WIDTH-1:0] r_s_ctrl;
    logic [DATA_WIDTH-1:0] r_s_dat;

    assign in_ready = !r_s_vld;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_vld  <= 1'b0;
            r_m_ctrl <= '0;
            r_m_dat  <= '0;
            r_s_vld  <= 1'b0;
            r_s_ctrl <= '0;
            r_s_dat  <= '0;
        end else if (flush) begin
            r_m_vld <= 1'b0;
            r_s_vld <= 1'b0;
        end else if (w_m_free) begin
            if (r_s_vld) begin
                // S is older than any new input, so it moves up first.
                r_m_vld  <= 1'b1;
                r_m_ctrl <= r_s_ctrl;
                r_m_dat  <= r_s_dat;
                r_s_vld  <= w_in_xfer;
                if (w_in_xfer) begin
                    r_s_ctrl <= in_ctrl;
                    r_s_dat  <= in_data;
                end
            end else begin
                r_m_vld <= w_in_xfer;
                if (w_in_xfer) begin
                    r_m_ctrl <= in_ctrl;
                    r_m_dat  <= in_data;
                end
            end
        end else if (w_in_xfer) begin
            r_s_vld  <= 1'b1;
            r_s_ctrl <= in_ctrl;
            r_s_dat  <= in_data;
        end
    end

    assign occupancy = {1'b0, r_m_vld} + {1'b0, r_s_vld};
`else
    assign in_ready = w_m_free;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_vld  <= 1'b0;
            r_m_ctrl <= '0;
            r_m_dat  <= '0;
        end else if (flush) begin
            r_m_vld <= 1'b0;
        end else if (w_m_free) begin
            r_m_vld <= w_in_xfer;
            if (w_in_xfer) begin
                r_m_ctrl <= in_ctrl;
                r_m_dat  <= in_data;
            end
        end
    end

    assign occupancy = {1'b0, r_m_vld};
`endif

    assign out_valid = r_m_vld;
    assign out_ctrl  = r_m_vld ? r_m_ctrl : CTRL_SAFE;
    assign out_data  = r_m_dat;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; covers both the default and PIPE_STAGE_SKID_EN builds.
module tb_pipe_stage_reg;

    logic         clk;
    logic         reset_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_ctrl;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_ctrl;
    logic [127:0] out_data;
    logic [1:0]   occupancy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [135:0] sb[$];

    pipe_stage_reg dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] dat(input int i);
        logic [31:0] t;
        t = 32'hD000_0000 + i[31:0];
        return {96'h0, t};
    endfunction

    function automatic logic [7:0] ctl(input int i);
        logic [7:0] t;
        t = 8'h10 + i[7:0];
        return t;
    endfunction

    task automatic offer(input logic v, input int i, input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = ctl(i);
        in_data   = dat(i);
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected-response producer: record each accepted input, forget everything on flush/reset.
    always @(posedge clk) begin
        if (reset_n) begin
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
        end
    end

    always @(negedge reset_n) sb.delete();

    // Output monitor: every output transfer must match the oldest outstanding item.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {out_ctrl, out_data}, 136'h0);
            end else begin
                logic [135:0] e;
                e = sb.pop_front();
                chk("sb_output", {24'h0, out_ctrl, out_data}, {24'h0, e});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        #1;
        // Reset held while upstream offers a transaction.
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'hFF;
        in_data   = {4{32'hDEAD_BEEF}};
        out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", {159'h0, out_valid}, 160'h0);
        chk("rst_out_ctrl", {152'h0, out_ctrl}, 160'h0);
        chk("rst_out_data", {32'h0, out_data}, 160'h0);
        chk("rst_occupancy", {158'h0, occupancy}, 160'h0);
        chk("rst_in_ready", {159'h0, in_ready}, 160'h1);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        tick();
        chk("post_rst_no_capture", {159'h0, out_valid}, 160'h0);

        // Streaming: one item per cycle, each visible right after its accepting edge.
        for (int i = 0; i < 10; i++) begin
            offer(1'b1, i, 1'b1, 1'b0);
            chk("stream_in_ready", {159'h0, in_ready}, 160'h1);
            tick();
            chk("stream_out_valid", {159'h0, out_valid}, 160'h1);
            chk("stream_out_data", {32'h0, out_data}, {32'h0, dat(i)});
        end
        offer(1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("stream_drained", {158'h0, occupancy}, 160'h0);
        chk("stream_idle_ctrl", {152'h0, out_ctrl}, 160'h0);

        // Back-pressure: A0 in M, then out_ready low for three cycles.
        offer(1'b1, 20, 1'b1, 1'b0);
        tick();
        chk("bp_occ1", {158'h0, occupancy}, 160'h1);
        offer(1'b1, 21, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_skid_ready", {159'h0, in_ready}, 160'h1);
        tick();
        chk("bp_occ2", {158'h0, occupancy}, 160'h2);
        chk("bp_full_not_ready", {159'h0, in_ready}, 160'h0);
        for (int k = 0; k < 2; k++) begin
            offer(1'b1, 22, 1'b0, 1'b0);
            tick();
            chk("bp_hold_occ", {158'h0, occupancy}, 160'h2);
            chk("bp_hold_ready", {159'h0, in_ready}, 160'h0);
            chk("bp_hold_data", {32'h0, out_data}, {32'h0, dat(20)});
        end
        offer(1'b1, 22, 1'b1, 1'b0);
        chk("bp_ready_registered", {159'h0, in_ready}, 160'h0);
        tick();
        chk("bp_s_to_m", {32'h0, out_data}, {32'h0, dat(21)});
        chk("bp_ready_back", {159'h0, in_ready}, 160'h1);
        offer(1'b1, 22, 1'b1, 1'b0);
        tick();
        chk("bp_last", {32'h0, out_data}, {32'h0, dat(22)});
`else
        for (int k = 0; k < 3; k++) begin
            offer(1'b1, 21, 1'b0, 1'b0);
            chk("bp_comb_not_ready", {159'h0, in_ready}, 160'h0);
            tick();
            chk("bp_occ_max1", {158'h0, occupancy}, 160'h1);
            chk("bp_hold_data", {32'h0, out_data}, {32'h0, dat(20)});
        end
        offer(1'b1, 21, 1'b1, 1'b0);
        chk("bp_comb_ready", {159'h0, in_ready}, 160'h1);
        tick();
        chk("bp_next", {32'h0, out_data}, {32'h0, dat(21)});
        chk("bp_occ_still1", {158'h0, occupancy}, 160'h1);
`endif
        offer(1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("bp_drained", {158'h0, occupancy}, 160'h0);
        chk("bp_sb_empty", {128'h0, 32'(sb.size())}, 160'h0);

`ifdef PIPE_STAGE_SKID_EN
        // Flush with both entries full and an input offered.
        offer(1'b1, 30, 1'b1, 1'b0);
        tick();
        offer(1'b1, 31, 1'b0, 1'b0);
        tick();
        chk("fl_full", {158'h0, occupancy}, 160'h2);
        offer(1'b1, 32, 1'b0, 1'b1);
        tick();
        chk("fl_full_occ", {158'h0, occupancy}, 160'h0);
        chk("fl_full_valid", {159'h0, out_valid}, 160'h0);
        chk("fl_full_ctrl", {152'h0, out_ctrl}, 160'h0);
`endif
        // Flush coinciding with input and output transfers: output completes, input dropped.
        offer(1'b1, 40, 1'b1, 1'b0);
        tick();
        offer(1'b1, 41, 1'b1, 1'b1);
        chk("fl_xfer_ready", {159'h0, in_ready}, 160'h1);
        tick();
        chk("fl_xfer_occ", {158'h0, occupancy}, 160'h0);
        chk("fl_xfer_valid", {159'h0, out_valid}, 160'h0);
        chk("fl_xfer_ctrl", {152'h0, out_ctrl}, 160'h0);
        offer(1'b0, 0, 1'b1, 1'b0);
        tick(); tick();
        chk("fl_nothing_leaks", {159'h0, out_valid}, 160'h0);

        // Asynchronous reset between edges with the stage loaded.
        offer(1'b1, 50, 1'b1, 1'b0);
        tick();
        offer(1'b1, 51, 1'b0, 1'b0);
        tick();
`ifdef PIPE_STAGE_SKID_EN
        chk("mr_loaded", {158'h0, occupancy}, 160'h2);
`else
        chk("mr_loaded", {158'h0, occupancy}, 160'h1);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_valid", {159'h0, out_valid}, 160'h0);
        chk("mr_occ", {158'h0, occupancy}, 160'h0);
        chk("mr_ctrl", {152'h0, out_ctrl}, 160'h0);
        chk("mr_data", {32'h0, out_data}, 160'h0);
        chk("mr_in_ready", {159'h0, in_ready}, 160'h1);
        tick();
        reset_n = 1'b1;
        offer(1'b1, 60, 1'b1, 1'b0);
        tick();
        chk("mr_first_valid", {159'h0, out_valid}, 160'h1);
        chk("mr_first_data", {32'h0, out_data}, {32'h0, dat(60)});
        chk("mr_first_ctrl", {152'h0, out_ctrl}, {152'h0, ctl(60)});
        offer(1'b0, 0, 1'b1, 1'b0);
        tick(); tick();
        chk("end_sb_empty", {128'h0, 32'(sb.size())}, 160'h0);
        chk("end_occ", {158'h0, occupancy}, 160'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
